// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port RAM with
// a 1-cycle registered read. Port 0 (data) can lock the RAM for atomic
// read-modify-write sequences; port 1 (instruction fetch) is shut out meanwhile.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [3:0]            m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [3:0]            m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {LOCK_OFF, LOCK_ON} lock_e;
  typedef enum logic {FAV_M0, FAV_M1} fav_e;

  lock_e                 lock_q, lock_d;
  fav_e                  fav_q, fav_d;
  logic                  rv0_q, rv1_q;
  logic                  gnt0, gnt1;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Grant decision plus next lock/pointer state
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    lock_d = lock_q;
    fav_d  = fav_q;
    if (reset) begin
      if (lock_q == LOCK_ON) begin
        gnt0 = m0_req;
      end else if (m0_req && m1_req) begin
        gnt0 = (fav_q == FAV_M0);
        gnt1 = (fav_q == FAV_M1);
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
    // Any port 0 grant re-arms or releases the lock from its own lock bit.
    if (gnt0) begin
      lock_d = m0_lock ? LOCK_ON : LOCK_OFF;
    end
    // Grants issued while locked leave the pointer alone, so port 1 wins first after release.
    if (lock_q == LOCK_OFF) begin
      if (gnt0) begin
        fav_d = FAV_M1;
      end else if (gnt1) begin
        fav_d = FAV_M0;
      end
    end
  end

  // Mux the granted port onto the RAM; park address/data on the last value when idle
  always_comb begin
    ram_en    = gnt0 | gnt1;
    ram_we    = '0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Arbitration state and read-response flags, synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      lock_q <= LOCK_OFF;
      fav_q  <= FAV_M0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      lock_q <= lock_d;
      fav_q  <= fav_d;
      rv0_q  <= gnt0 && (m0_we == 4'b0000);
      rv1_q  <= gnt1 && (m1_we == 4'b0000);
    end
  end

  // Remember the last driven address/data so idle cycles do not toggle the RAM bus
  always_ff @(posedge clk) begin
    // NOTE: these are pure datapath holding registers; their value only matters when ram_en
    // is low, so they carry no reset.
    if (ram_en) begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rv0_q && reset;
  assign m1_rvalid = rv1_q && reset;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_ram_arbiter;

  localparam int AW = 14;

  typedef struct packed {
    logic          req;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          lock;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_lock, m0_gnt, m0_rvalid;
  logic [3:0]    m0_we;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic          m1_req, m1_gnt, m1_rvalid;
  logic [3:0]    m1_we;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  // Randomized-run model state
  logic [31:0] ref_mem [int];
  txn_t        pend [2];
  int          last_served;
  bit          locked;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Power-on RAM contents, with two fixed words used by the directed tests
  function automatic logic [31:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    if (a == 'h20) return 32'hAAAAAAAA;
    return 32'hC0DE0000 ^ (a * 32'h00010101);
  endfunction

  // RAM model: 1-cycle registered read, byte-masked write
  logic [31:0] mem [int];
  always @(posedge clk) begin : ram_model
    logic [31:0] word;
    if (ram_en) begin
      word = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_val(int'(ram_addr));
      ram_rdata <= word;
      for (int b = 0; b < 4; b++) if (ram_we[b]) word[8*b +: 8] = ram_wdata[8*b +: 8];
      if (ram_we != 4'b0000) mem[int'(ram_addr)] = word;
    end
  end

  task automatic drive0(input bit req, input logic [3:0] we, input int addr,
                        input logic [31:0] wdata, input bit lock);
    m0_req = req; m0_we = we; m0_addr = AW'(addr); m0_wdata = wdata; m0_lock = lock;
  endtask

  task automatic drive1(input bit req, input logic [3:0] we, input int addr,
                        input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_addr = AW'(addr); m1_wdata = wdata;
  endtask

  task automatic idle();
    drive0(1'b0, 4'b0, 0, 32'h0, 1'b0);
    drive1(1'b0, 4'b0, 0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive0(1'b1, 4'b0, 'h1, 32'h0, 1'b0);
    drive1(1'b1, 4'hF, 'h2, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
      checks++; if (ram_we !== 4'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0000", ram_we); end
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
      next_cycle();
    end
    reset = 1'b1;
    drive1(1'b1, 4'b0, 'h2, 32'h0);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_conflict: got %b expected 10", {m0_gnt, m1_gnt}); end
    next_cycle();
    drive0(1'b0, 4'b0, 0, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL reset_second_gnt1: got %b expected 1", m1_gnt); end
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL reset_m0_rvalid: got %b expected 1", m0_rvalid); end
    checks++; if (m0_rdata !== init_val('h1)) begin errors++; $display("FAIL reset_m0_rdata: got %h expected %h", m0_rdata, init_val('h1)); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== init_val('h2)) begin errors++; $display("FAIL reset_m1_resp: got %b/%h expected 1/%h", m1_rvalid, m1_rdata, init_val('h2)); end
    next_cycle();
  endtask

  task automatic test_single_read();
    drive1(1'b1, 4'b0, 'h10, 32'h0);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", {m0_gnt, m1_gnt}); end
    checks++; if (ram_en !== 1'b1 || ram_we !== 4'b0) begin errors++; $display("FAIL single_ram_ctl: got en=%b we=%b expected en=1 we=0000", ram_en, ram_we); end
    checks++; if (ram_addr !== AW'('h10)) begin errors++; $display("FAIL single_ram_addr: got %h expected 0010", ram_addr); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b expected 1", m1_rvalid); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_m0_rvalid: got %b expected 0", m0_rvalid); end
    next_cycle();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_pulse: got %b expected 0", m1_rvalid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int a0 = 'h100;
    int a1 = 'h200;
    int prev = -1;
    int exp_port;
    logic [31:0] prev_data = 32'h0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        drive0(1'b1, 4'b0, a0, 32'h0, 1'b0);
        drive1(1'b1, 4'b0, a1, 32'h0);
      end else begin
        idle();
      end
      @(negedge clk);
      exp_port = i % 2;
      if (i < 6) begin
        checks++; if (m0_gnt !== (exp_port == 0) || m1_gnt !== (exp_port == 1)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b%b expected port %0d", i, m0_gnt, m1_gnt, exp_port); end
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL b2b_ram_en[%0d]: got %b expected 1", i, ram_en); end
        checks++; if (ram_addr !== AW'(exp_port == 1 ? a1 : a0)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, ram_addr, AW'(exp_port == 1 ? a1 : a0)); end
      end
      if (prev >= 0) begin
        checks++; if (m0_rvalid !== (prev == 0) || m1_rvalid !== (prev == 1)) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b%b expected port %0d", i, m0_rvalid, m1_rvalid, prev); end
        checks++; if ((prev == 0 ? m0_rdata : m1_rdata) !== prev_data) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, (prev == 0 ? m0_rdata : m1_rdata), prev_data); end
      end
      if (i < 6) begin
        prev = exp_port;
        prev_data = init_val(exp_port == 1 ? a1 : a0);
        if (exp_port == 1) a1++; else a0++;
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read();
    drive0(1'b1, 4'b0011, 'h20, 32'h12345678, 1'b0);
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b expected 1", m0_gnt); end
    checks++; if (ram_we !== 4'b0011) begin errors++; $display("FAIL wr_ram_we: got %b expected 0011", ram_we); end
    checks++; if (ram_addr !== AW'('h20) || ram_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_ram_bus: got %h/%h expected 0020/12345678", ram_addr, ram_wdata); end
    next_cycle();
    drive0(1'b0, 4'b0, 0, 32'h0, 1'b0);
    drive1(1'b1, 4'b0, 'h20, 32'h0);
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", m0_rvalid); end
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL wr_read_gnt: got %b expected 1", m1_gnt); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hAAAA5678) begin errors++; $display("FAIL wr_readback: got %b/%h expected 1/aaaa5678", m1_rvalid, m1_rdata); end
    next_cycle();
  endtask

  task automatic test_lock();
    drive0(1'b1, 4'b0, 'h30, 32'h0, 1'b1);
    drive1(1'b1, 4'b0, 'h40, 32'h0);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_set_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    next_cycle();
    drive0(1'b1, 4'hF, 'h31, 32'h0BADF00D, 1'b1);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_held_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val('h30)) begin errors++; $display("FAIL lock_read_resp: got %b/%h expected 1/%h", m0_rvalid, m0_rdata, init_val('h30)); end
    next_cycle();
    drive0(1'b0, 4'b0, 0, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL lock_m1_blocked: got gnt=%b en=%b expected 0/0", m1_gnt, ram_en); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL lock_write_no_rvalid: got %b expected 0", m0_rvalid); end
    next_cycle();
    drive0(1'b1, 4'b0, 'h32, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL lock_release_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    next_cycle();
    drive0(1'b1, 4'b0, 'h31, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL lock_after_release: got %b expected 01", {m0_gnt, m1_gnt}); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val('h32)) begin errors++; $display("FAIL lock_release_resp: got %b/%h expected 1/%h", m0_rvalid, m0_rdata, init_val('h32)); end
    next_cycle();
    drive1(1'b0, 4'b0, 0, 32'h0);
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL lock_m0_resume: got %b expected 1", m0_gnt); end
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== init_val('h40)) begin errors++; $display("FAIL lock_m1_resp: got %b/%h expected 1/%h", m1_rvalid, m1_rdata, init_val('h40)); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL lock_locked_write: got %b/%h expected 1/0badf00d", m0_rvalid, m0_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 4'b0, 'h50, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b expected 1", m0_gnt); end
    next_cycle();
    idle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid_in_reset: got %b expected 0", m0_rvalid); end
    next_cycle();
    reset = 1'b1;
    drive0(1'b1, 4'b0, 'h51, 32'h0, 1'b0);
    drive1(1'b1, 4'b0, 'h10, 32'h0);
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid_after: got %b expected 0", m0_rvalid); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rmid_ptr_reset: got %b expected 10", {m0_gnt, m1_gnt}); end
    next_cycle();
    drive0(1'b0, 4'b0, 0, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rmid_m1_gnt: got %b expected 1", m1_gnt); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val('h51)) begin errors++; $display("FAIL rmid_m0_resp: got %b/%h expected 1/%h", m0_rvalid, m0_rdata, init_val('h51)); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_m1_resp: got %b/%h expected 1/deadbeef", m1_rvalid, m1_rdata); end
    next_cycle();
  endtask

  function automatic txn_t new_txn();
    txn_t t;
    t.req   = 1'b1;
    t.addr  = AW'(32'h100 + $urandom_range(0, 31));
    t.we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    t.wdata = $urandom;
    t.lock  = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic test_random();
    int win;
    logic [31:0] word;
    int a;
    idle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    last_served = 1;
    locked = 1'b0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    pend[0] = '0; pend[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) if (!pend[p].req && $urandom_range(0, 9) < 6) pend[p] = new_txn();
      reset = ($urandom_range(0, 63) != 0);
      drive0(pend[0].req, pend[0].we, int'(pend[0].addr), pend[0].wdata, pend[0].lock);
      drive1(pend[1].req, pend[1].we, int'(pend[1].addr), pend[1].wdata);
      if (!reset) win = -1;
      else if (locked) win = pend[0].req ? 0 : -1;
      else if (pend[0].req && pend[1].req) win = 1 - last_served;
      else if (pend[0].req) win = 0;
      else if (pend[1].req) win = 1;
      else win = -1;
      @(negedge clk);
      checks++; if (m0_gnt !== (win == 0) || m1_gnt !== (win == 1)) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b%b expected winner %0d", cyc, m0_gnt, m1_gnt, win); end
      checks++; if (ram_en !== (win >= 0)) begin errors++; $display("FAIL rnd_ram_en[%0d]: got %b expected %b", cyc, ram_en, win >= 0); end
      if (win >= 0) begin
        checks++; if (ram_we !== pend[win].we || ram_addr !== pend[win].addr || ram_wdata !== pend[win].wdata) begin errors++; $display("FAIL rnd_ram_bus[%0d]: got %b/%h/%h expected %b/%h/%h", cyc, ram_we, ram_addr, ram_wdata, pend[win].we, pend[win].addr, pend[win].wdata); end
      end else begin
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL rnd_ram_we_idle[%0d]: got %b expected 0000", cyc, ram_we); end
      end
      checks++; if (m0_rvalid !== (exp_rv[0] && reset) || m1_rvalid !== (exp_rv[1] && reset)) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", cyc, m0_rvalid, m1_rvalid, exp_rv[0] && reset, exp_rv[1] && reset); end
      if (exp_rv[0] && reset) begin
        checks++; if (m0_rdata !== exp_rd[0]) begin errors++; $display("FAIL rnd_m0_rdata[%0d]: got %h expected %h", cyc, m0_rdata, exp_rd[0]); end
      end
      if (exp_rv[1] && reset) begin
        checks++; if (m1_rdata !== exp_rd[1]) begin errors++; $display("FAIL rnd_m1_rdata[%0d]: got %h expected %h", cyc, m1_rdata, exp_rd[1]); end
      end
      @(posedge clk);
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      if (!reset) begin
        last_served = 1;
        locked = 1'b0;
      end else if (win >= 0) begin
        a = int'(pend[win].addr);
        word = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (pend[win].we == 4'b0000) begin
          exp_rv[win] = 1'b1;
          exp_rd[win] = word;
        end else begin
          for (int b = 0; b < 4; b++) if (pend[win].we[b]) word[8*b +: 8] = pend[win].wdata[8*b +: 8];
          ref_mem[a] = word;
        end
        if (!locked) last_served = win;
        if (win == 0) locked = pend[0].lock;
        pend[win].req = 1'b0;
      end
      #1;
    end
    reset = 1'b1;
    idle();
    next_cycle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_then_read();
    test_lock();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
